// File: rtl/fsm_main_pkg.sv
// Shared types and constants for the fsm_main board block.
package fsm_main_pkg;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;

    // Active-low {dp,g,f,e,d,c,b,a} codes, entry n is hex digit n.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_A    = 8'h88;

    // Active-low one-hot digit selects, entry n drives digit n.
    localparam logic [3:0][3:0] SEL_PAT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/fsm_main_seg7_scan.sv
// Four-digit multiplexed seven-segment scanner: scan counter, select and segment mux.
import fsm_main_pkg::*;

module seg7_scan #(
    parameter int unsigned SCAN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [7:0] d1_raw,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [3:0] sel,
    output logic [7:0] data
);

    localparam int unsigned SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    logic [SC_W-1:0] scan_cnt;
    logic [SC_W-1:0] scan_cnt_next;
    logic [1:0]      idx;
    logic [1:0]      idx_next;
    logic [7:0]      seg_next;

    // Next scan position and the segment pattern for the digit it selects.
    always_comb begin
        scan_cnt_next = scan_cnt + SC_W'(1);
        idx_next      = idx;
        seg_next      = SEG_DASH;
        if (scan_cnt == SC_W'(SCAN_CYCLES - 1)) begin
            scan_cnt_next = '0;
            idx_next      = idx + 2'd1;
        end
        case (idx_next)
            2'd0:    seg_next = HEX_SEG[d0];
            2'd1:    seg_next = d1_raw;
            2'd2:    seg_next = HEX_SEG[d2];
            default: seg_next = HEX_SEG[d3];
        endcase
    end

    // Register scan position, select and segments together so they switch on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            sel      <= SEL_PAT[0];
            data     <= HEX_SEG[0];
        end else begin
            scan_cnt <= scan_cnt_next;
            idx      <= idx_next;
            sel      <= SEL_PAT[idx_next];
            data     <= seg_next | 8'h80;
        end
    end

endmodule

// File: rtl/fsm_main.sv
// Eight-state cyclic FSM board top with manual/auto step, LED bank and 4-digit display.
// Optional: define LED_BAR_EN for a thermometer LED bar instead of one-hot.
import fsm_main_pkg::*;

module fsm_main #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STEP_CYCLES     = 16,
    parameter int unsigned SCAN_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       button,
    output logic [7:0] Led,
    output logic [3:0] sel,
    output logic [7:0] data
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ST_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic            key_s1, key_s2, btn_s1, btn_s2;
    logic            db_level;
    logic [DB_W-1:0] db_cnt;
    logic            step_pulse;
    logic [ST_W-1:0] step_timer;
    logic            tick;
    state_t          state, state_next;
    logic [7:0]      count, count_next;
    logic [7:0]      led_next;

    // Two-flop synchronizers for the asynchronous key and button.
    always_ff @(posedge clk) begin
        if (rst) begin
            {key_s1, key_s2, btn_s1, btn_s2} <= '0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            btn_s1 <= button;
            btn_s2 <= btn_s1;
        end
    end

    // Debouncer; a press is accepted only after a full run of differing samples, release is silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_level   <= 1'b0;
            db_cnt     <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (btn_s2 != db_level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level   <= btn_s2;
                    db_cnt     <= '0;
                    step_pulse <= btn_s2;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign tick = key_s2 && (step_timer == ST_W'(STEP_CYCLES - 1));

    // Auto-step timer, parked at zero while manual mode is selected.
    always_ff @(posedge clk) begin
        if (rst || !key_s2 || tick) begin
            step_timer <= '0;
        end else begin
            step_timer <= step_timer + ST_W'(1);
        end
    end

    // State, transition counter and LED registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
            count <= 8'd0;
            Led   <= 8'h01;
        end else begin
            state <= state_next;
            count <= count_next;
            Led   <= led_next;
        end
    end

    // Advance once per cycle on either event, and derive the LED pattern of the next state.
    always_comb begin
        state_next = state;
        count_next = count;
        led_next   = 8'h00;
        if (step_pulse || tick) begin
            state_next = state_t'(3'(state) + 3'd1);
            count_next = count + 8'd1;
        end
`ifdef LED_BAR_EN
        for (int i = 0; i < 8; i++) begin
            led_next[i] = (3'(i) <= 3'(state_next));
        end
`else
        led_next = 8'h01 << 3'(state_next);
`endif
    end

    // Display fed with next-cycle values so digits track the state registers exactly.
    seg7_scan #(
        .SCAN_CYCLES(SCAN_CYCLES)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .d0     ({1'b0, 3'(state_next)}),
        .d1_raw (key_s1 ? SEG_A : SEG_DASH),
        .d2     (count_next[3:0]),
        .d3     (count_next[7:4]),
        .sel    (sel),
        .data   (data)
    );

endmodule

// File: tb/tb_fsm_main.sv
// Self-checking bench for fsm_main: behavioural model plus directed literal checks.
module tb_fsm_main;

    localparam int DB   = 4;
    localparam int STEP = 16;
    localparam int SCAN = 4;

`ifdef LED_BAR_EN
    localparam logic [7:0] LED_S1 = 8'h03;
    localparam logic [7:0] LED_S3 = 8'h0F;
`else
    localparam logic [7:0] LED_S1 = 8'h02;
    localparam logic [7:0] LED_S3 = 8'h08;
`endif

    logic       clk = 1'b0;
    logic       rst, key, button;
    logic [7:0] Led;
    logic [3:0] sel;
    logic [7:0] data;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    fsm_main #(.DEBOUNCE_CYCLES(DB), .STEP_CYCLES(STEP), .SCAN_CYCLES(SCAN)) dut (
        .clk(clk), .rst(rst), .key(key), .button(button),
        .Led(Led), .sel(sel), .data(data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h want %02h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: integers and spec rules, sampled on the same edge as the DUT.
    bit m_valid = 0;
    int m_state, m_count, m_total, scan_n, key_run, diff_run;
    bit m_k1, m_ks, m_b1, m_bs, m_db, m_pulse, adv;

    always @(posedge clk) begin
        m_valid = 1;
        if (rst) begin
            m_state = 0; m_count = 0; scan_n = 0; key_run = 0; diff_run = 0;
            m_k1 = 0; m_ks = 0; m_b1 = 0; m_bs = 0; m_db = 0; m_pulse = 0;
        end else begin
            adv = m_pulse;
            m_pulse = 0;
            if (m_ks) begin
                key_run++;
                if (key_run % STEP == 0) adv = 1;
            end else begin
                key_run = 0;
            end
            if (m_bs != m_db) begin
                diff_run++;
                if (diff_run == DB) begin
                    m_db = m_bs;
                    diff_run = 0;
                    if (m_bs) m_pulse = 1;
                end
            end else begin
                diff_run = 0;
            end
            if (adv) begin
                m_state = (m_state + 1) % 8;
                m_count = (m_count + 1) % 256;
                m_total++;
            end
            m_ks = m_k1; m_k1 = key;
            m_bs = m_b1; m_b1 = button;
            scan_n++;
        end
    end

    function automatic logic [7:0] model_led(input int s);
`ifdef LED_BAR_EN
        return 8'((16'd2 << s) - 16'd1);
`else
        return 8'(16'd1 << s);
`endif
    endfunction

    int         e_idx;
    logic [7:0] e_data;

    // Compare every cycle once the model has seen a clock edge.
    always @(negedge clk) begin
        if (m_valid) begin
            e_idx = (scan_n / SCAN) % 4;
            case (e_idx)
                0:       e_data = hex_tab[m_state];
                1:       e_data = m_ks ? 8'h88 : 8'hBF;
                2:       e_data = hex_tab[m_count % 16];
                default: e_data = hex_tab[m_count / 16];
            endcase
            chk("led", Led, model_led(m_state));
            chk("sel", {4'h0, sel}, {4'h0, ~(4'b0001 << e_idx)});
            chk("data", data, e_data);
        end
    end

    task automatic show(input string nm, input logic [3:0] p, input logic [7:0] exp);
        bit ok = 0;
        for (int i = 0; i < 4 * SCAN + 2; i++) begin
            @(negedge clk);
            if (sel === p) begin
                ok = 1;
                break;
            end
        end
        if (ok) chk(nm, data, exp);
        else chk({nm, "_sel_timeout"}, {4'h0, sel}, {4'h0, p});
    endtask

    task automatic press();
        @(negedge clk) button = 1;
        repeat (10) @(negedge clk);
        button = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; key = 0; button = 0;
        @(negedge clk);
        rst = 0;
    endtask

    int t0;

    initial begin
        rst = 1; key = 0; button = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_led", Led, 8'h01);
        chk("rst_sel", {4'h0, sel}, 8'h0E);
        chk("rst_data", data, 8'hC0);
        chk("rst_model_cnt", 8'(m_count), 8'd0);

        // Manual stepping
        repeat (3) press();
        chk("man_led", Led, LED_S3);
        chk("man_model_cnt", 8'(m_count), 8'd3);
        show("man_d0", 4'b1110, 8'hB0);
        show("man_d1", 4'b1101, 8'hBF);
        show("man_d2", 4'b1011, 8'hB0);
        show("man_d3", 4'b0111, 8'hC0);

        // Bounce rejection
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) button = ~button;
            @(negedge clk);
        end
        button = 0;
        repeat (12) @(negedge clk);
        chk("bounce_led", Led, LED_S3);
        show("bounce_d2", 4'b1011, 8'hB0);

        // Auto mode from S0
        do_reset();
        key = 1; t0 = cyc;
        repeat (20) @(negedge clk);
        show("auto_d1", 4'b1101, 8'h88);
        while (cyc < t0 + 8 * STEP + 10) @(posedge clk);
        @(negedge clk) key = 0;
        repeat (4) @(negedge clk);
        chk("auto_led", Led, 8'h01);
        chk("auto_model_cnt", 8'(m_count), 8'd8);
        show("auto_d2", 4'b1011, 8'h80);
        show("auto_d1_off", 4'b1101, 8'hBF);

        // Step pulse coincident with a tick
        do_reset();
        key = 1;
        repeat (11) @(negedge clk);
        button = 1;
        repeat (10) @(negedge clk);
        button = 0; key = 0;
        repeat (10) @(negedge clk);
        chk("simul_led", Led, LED_S1);
        chk("simul_model_cnt", 8'(m_count), 8'd1);
        show("simul_d2", 4'b1011, 8'hF9);

        // Counter wrap after 256 advances
        do_reset();
        key = 1; t0 = cyc;
        while (cyc < t0 + 2 + 256 * STEP) @(posedge clk);
        @(negedge clk) key = 0;
        repeat (4) @(negedge clk);
        chk("wrap_led", Led, 8'h01);
        chk("wrap_model_cnt", 8'(m_count), 8'd0);
        show("wrap_d2", 4'b1011, 8'hC0);
        show("wrap_d3", 4'b0111, 8'hC0);

        // Reset in the middle of auto operation with a press in flight
        key = 1;
        repeat (30) @(negedge clk);
        chk("mid_led_pre", Led, LED_S1);
        button = 1;
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_led", Led, 8'h01);
        chk("mid_rst_sel", {4'h0, sel}, 8'h0E);
        chk("mid_rst_data", data, 8'hC0);
        rst = 0; key = 0; button = 0;
        repeat (10) @(negedge clk);
        chk("mid_post_led", Led, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_main.md
Name: fsm_main

Overview:
- Eight-state cyclic state machine with manual-step and auto-step modes.
- Current state is shown on an 8-LED bank and on a 4-digit multiplexed seven-segment display, together with the mode and a transition counter.
- Top-level board block: drives LEDs and display directly from the key and button inputs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a button level is accepted.
- STEP_CYCLES, 16: cycles between automatic advances while auto mode is active.
- SCAN_CYCLES, 4: cycles each display digit stays selected.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- key  in  1  mode select, level; 1 = auto-step, 0 = manual. Asynchronous to clk.
- button  in  1  manual step pushbutton, active-high. Asynchronous to clk.
- Led  out  8  state indicator.
- sel  out  4  digit select, active-low one-hot.
- data  out  8  segment bits {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high; every register clears on the clk edge where rst=1.
- Input conditioning:
  - key and button each pass through a 2-flop synchronizer.
  - The synchronized button feeds a debouncer. The debounced level changes only after the raw synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A one-cycle step pulse is generated on a debounced 0->1 transition. Release generates nothing.
- Auto tick:
  - A step timer counts while synchronized key=1.
  - When it reaches STEP_CYCLES-1 it emits a one-cycle tick and restarts at 0.
  - The timer is held at 0 while key=0, so the first auto advance occurs STEP_CYCLES cycles after synchronized key rises.
- State machine:
  - States S0..S7, 3-bit encoding.
  - On any advance event (step pulse OR tick): state <= state+1, wrapping S7->S0.
  - Button pulse and tick in the same cycle produce exactly one advance.
  - Button presses are honoured in both modes.
- Transition counter: 8-bit, +1 per advance, wraps 255->0.
- Led: one-hot, Led[state]=1.
- Display scan:
  - A digit index 0..3 advances every SCAN_CYCLES cycles, wrapping 3->0.
  - sel values for index 0..3: 4'b1110, 4'b1101, 4'b1011, 4'b0111.
  - Digit content: digit0 = state as hex; digit1 = 'A' (8'h88) if synchronized key=1, else '-' (8'hBF); digit2 = counter[3:0]; digit3 = counter[7:4].
  - sel and data change on the same edge. dp is always off (bit7=1).
- Hex codes, 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Reset values:
  - state=S0, counter=0, step timer=0, scan index=0, debounced level=0, synchronizers=0.
  - Led=8'h01, sel=4'b1110, data=8'hC0.
- Reset asserted mid-operation: all of the above reload on the next edge. A step pulse or tick coincident with rst is discarded.

Optional Feature:
- Macro LED_BAR_EN.
- When defined: Led is a thermometer bar, Led[i]=1 for all i<=state (S0 -> 8'h01, S7 -> 8'hFF).
- When undefined: one-hot as specified above. Reset value 8'h01 in both cases.

Decomposition:
- Package fsm_main_pkg holds:
  - the state typedef (S0..S7, 3-bit);
  - the 16-entry active-low hex segment constant table;
  - SEG_DASH = 8'hBF and SEG_A = 8'h88;
  - the SEL pattern constants.
- One sub-module, seg7_scan: scan counter, sel generation and digit-to-segment mux/decoder. It takes four 4-bit/raw digit inputs plus the SCAN_CYCLES parameter.

Test Plan:
- Reset: rst=1 for 3 cycles, then 0 -> Led=8'h01, sel=4'b1110, data=8'hC0, counter=0.
- Manual step: key=0, 3 clean button presses (each held 10 cycles) -> Led=8'h08, counter=3; digit0 shows 8'hB0 when sel=4'b1110.
- Bounce rejection: button toggles every 2 cycles for 20 cycles, then settles at 0 -> no advance, Led unchanged.
- Auto mode: key=1 held 8*STEP_CYCLES+10 cycles from S0 -> 8 advances, state wraps to S0 (Led=8'h01), counter=8. While key=1, digit1 = 8'h88.
- Simultaneous events: step pulse forced in the same cycle as a tick -> exactly one advance, counter +1.
- Counter wrap: 256 advances -> counter 0; with sel=4'b0111 and sel=4'b1011 both digits show 8'hC0. A mid-run rst restores all reset values on the next edge.
